aim65_kbd_matrix: RTL and testbench

- Emulates the AIM-65 8x8 keyboard matrix behind the user VIA's port B (column drive) and port A (row sense).
- Consumes decoded PS/2 set-2 bytes from the host keyboard front end and maintains a 64-bit key-state matrix.
- Answers VIA column scans with active-low row data, registered one clock later.
- Output row_out drives via paIn; input col_sel is taken from via pbOut.

---
 rtl/aim65_kbd_matrix_if.sv | 29 ++
 rtl/aim65_kbd_matrix.sv | 224 ++++++++++++++++++++++
 tb/tb_aim65_kbd_matrix.sv | 386 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aim65_kbd_matrix_if.sv
// aim65_kbd_matrix_if
// Bundles the host-keyboard byte stream and the VIA-facing scan signals of
// the AIM-65 keyboard matrix emulator.
//   kbd_code  [7:0] PS/2 set-2 byte from the keyboard front end
//   kbd_valid       one-cycle strobe qualifying kbd_code
//   col_sel   [7:0] column drive from VIA port B, active low
//   row_out   [7:0] row sense to VIA port A, active low
//   any_key         high while any matrix key is held
//   busy            high while the byte decoder is mid-sequence
// master: keyboard/VIA side that drives bytes and columns.
// slave : the matrix emulator itself.
interface aim65_kbd_matrix_if;
  logic [7:0] kbd_code;
  logic       kbd_valid;
  logic [7:0] col_sel;
  logic [7:0] row_out;
  logic       any_key;
  logic       busy;

  modport master (
    output kbd_code, kbd_valid, col_sel,
    input  row_out, any_key, busy
  );

  modport slave (
    input  kbd_code, kbd_valid, col_sel,
    output row_out, any_key, busy
  );
endinterface

// File: rtl/aim65_kbd_matrix.sv
// aim65_kbd_matrix
// Emulates the AIM-65 8x8 keyboard matrix seen by the user VIA. Decoded PS/2
// set-2 bytes update a 64-bit key-state matrix; VIA column scans are answered
// with active-low row data one clock later.
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high reset
//   bus    aim65_kbd_matrix_if.slave (kbd_code, kbd_valid, col_sel in;
//          row_out, any_key, busy out)
// Key index is col*8 + row.
module aim65_kbd_matrix #(
  parameter int E1_SKIP      = 7,
  parameter int RELEASE_HOLD = 1
) (
  input  logic                clk,
  input  logic                reset,
  aim65_kbd_matrix_if.slave   bus
);

  localparam int SKIP_W = (E1_SKIP < 1) ? 1 : $clog2(E1_SKIP + 1);
  localparam int HOLD_W = (RELEASE_HOLD < 1) ? 1 : $clog2(RELEASE_HOLD + 1);
  localparam logic [SKIP_W-1:0] SKIP_INIT = SKIP_W'(E1_SKIP);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(RELEASE_HOLD);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_SKIP
  } state_t;

  state_t             state, state_next;
  logic [SKIP_W-1:0]  skip_cnt, skip_cnt_next;

  logic [63:0]        key, key_next;
  logic [63:0]        pending, pending_next;
  logic [HOLD_W-1:0]  seen [64];
  logic [HOLD_W-1:0]  seen_next [64];
  logic [7:0]         col_prev;
  logic [7:0]         row_q;
  logic               any_q;

  logic               make_ev, break_ev, clear_all, ev_ext;
  logic [6:0]         lookup;
  logic [63:0]        hit_vec;
  logic               scan_evt;
  logic [7:0]         rows_hit;

  // Fixed translation table: {hit, col[2:0], row[2:0]}.
  function automatic logic [6:0] map_code(input logic ext, input logic [7:0] code);
    logic [6:0] m;
    m = 7'd0;
    if (!ext) begin
      case (code)
        8'h5A: m = {1'b1, 3'd0, 3'd0};  // RETURN
        8'h29: m = {1'b1, 3'd0, 3'd1};  // SPACE
        8'h66: m = {1'b1, 3'd0, 3'd2};  // DEL
        8'h76: m = {1'b1, 3'd0, 3'd3};  // ESC
        8'h16: m = {1'b1, 3'd1, 3'd0};  // 1
        8'h1E: m = {1'b1, 3'd1, 3'd1};  // 2
        8'h26: m = {1'b1, 3'd1, 3'd2};  // 3
        8'h25: m = {1'b1, 3'd1, 3'd3};  // 4
        8'h15: m = {1'b1, 3'd2, 3'd0};  // Q
        8'h1D: m = {1'b1, 3'd2, 3'd1};  // W
        8'h24: m = {1'b1, 3'd2, 3'd2};  // E
        8'h2D: m = {1'b1, 3'd2, 3'd3};  // R
        8'h1C: m = {1'b1, 3'd3, 3'd2};  // A
        8'h1B: m = {1'b1, 3'd3, 3'd3};  // S
        8'h23: m = {1'b1, 3'd3, 3'd4};  // D
        8'h2B: m = {1'b1, 3'd3, 3'd5};  // F
        8'h1A: m = {1'b1, 3'd4, 3'd0};  // Z
        8'h22: m = {1'b1, 3'd4, 3'd1};  // X
        8'h21: m = {1'b1, 3'd4, 3'd2};  // C
        8'h2A: m = {1'b1, 3'd4, 3'd3};  // V
        8'h14: m = {1'b1, 3'd7, 3'd6};  // CTRL
        8'h12,
        8'h59: m = {1'b1, 3'd7, 3'd7};  // both shifts share one key
        default: m = 7'd0;
      endcase
    end else begin
      case (code)
        8'h75: m = {1'b1, 3'd1, 3'd5};  // up
        8'h72: m = {1'b1, 3'd1, 3'd6};  // down
        8'h6B: m = {1'b1, 3'd2, 3'd6};  // left
        8'h74: m = {1'b1, 3'd2, 3'd7};  // right
        default: m = 7'd0;
      endcase
    end
    return m;
  endfunction

  // Prefix decoder state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      skip_cnt <= '0;
    end else begin
      state    <= state_next;
      skip_cnt <= skip_cnt_next;
    end
  end

  // Prefix decoder: classifies each byte as make, break, clear or prefix.
  always_comb begin
    state_next    = state;
    skip_cnt_next = skip_cnt;
    make_ev       = 1'b0;
    break_ev      = 1'b0;
    clear_all     = 1'b0;
    ev_ext        = 1'b0;
    if (bus.kbd_valid) begin
      case (state)
        ST_IDLE: begin
          case (bus.kbd_code)
            8'hE0: state_next = ST_EXT;
            8'hF0: state_next = ST_BRK;
            8'hE1: begin
              if (E1_SKIP > 0) begin
                state_next    = ST_SKIP;
                skip_cnt_next = SKIP_INIT;
              end
            end
            8'hAA, 8'hFF: clear_all = 1'b1;
            default: make_ev = 1'b1;
          endcase
        end
        ST_EXT: begin
          if (bus.kbd_code == 8'hF0) begin
            state_next = ST_EXT_BRK;
          end else begin
            make_ev    = 1'b1;
            ev_ext     = 1'b1;
            state_next = ST_IDLE;
          end
        end
        ST_BRK: begin
          break_ev   = 1'b1;
          state_next = ST_IDLE;
        end
        ST_EXT_BRK: begin
          break_ev   = 1'b1;
          ev_ext     = 1'b1;
          state_next = ST_IDLE;
        end
        ST_SKIP: begin
          skip_cnt_next = skip_cnt - SKIP_W'(1);
          if (skip_cnt <= SKIP_W'(1)) state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  assign lookup  = map_code(ev_ext, bus.kbd_code);
  assign hit_vec = lookup[6] ? (64'd1 << lookup[5:0]) : 64'd0;

  // Per-key update. The scan count is bumped before the break/pending
  // decision so a break landing on a scan edge can release immediately,
  // and a make always beats a pending release on the same key.
  always_comb begin
    scan_evt     = (bus.col_sel != col_prev);
    key_next     = key;
    pending_next = pending;
    for (int i = 0; i < 64; i++) begin
      seen_next[i] = seen[i];
      if (key[i] && !bus.col_sel[i[5:3]] && scan_evt && (seen[i] < HOLD_MAX))
        seen_next[i] = seen[i] + HOLD_W'(1);
      if (clear_all) begin
        key_next[i]     = 1'b0;
        pending_next[i] = 1'b0;
        seen_next[i]    = '0;
      end else if (make_ev && hit_vec[i]) begin
        if (!key[i]) seen_next[i] = '0;
        key_next[i]     = 1'b1;
        pending_next[i] = 1'b0;
      end else if (break_ev && hit_vec[i] && key[i]) begin
        if (seen_next[i] >= HOLD_MAX) begin
          key_next[i]     = 1'b0;
          pending_next[i] = 1'b0;
          seen_next[i]    = '0;
        end else begin
          pending_next[i] = 1'b1;
        end
      end else if (pending[i] && (seen_next[i] >= HOLD_MAX)) begin
        key_next[i]     = 1'b0;
        pending_next[i] = 1'b0;
        seen_next[i]    = '0;
      end
    end
  end

  // Wired-OR of the rows of every selected column; no ghost suppression.
  always_comb begin
    rows_hit = 8'h00;
    for (int c = 0; c < 8; c++) begin
      if (!bus.col_sel[c]) rows_hit = rows_hit | key[c*8 +: 8];
    end
  end

  // Matrix state and registered VIA-facing outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key      <= '0;
      pending  <= '0;
      for (int i = 0; i < 64; i++) seen[i] <= '0;
      col_prev <= 8'hFF;
      row_q    <= 8'hFF;
      any_q    <= 1'b0;
    end else begin
      key      <= key_next;
      pending  <= pending_next;
      for (int i = 0; i < 64; i++) seen[i] <= seen_next[i];
      col_prev <= bus.col_sel;
      row_q    <= ~rows_hit;
      any_q    <= |key;
    end
  end

  assign bus.row_out = row_q;
  assign bus.any_key = any_q;
  assign bus.busy    = (state != ST_IDLE);

endmodule

// File: tb/tb_aim65_kbd_matrix.sv
// tb_aim65_kbd_matrix
// Self-checking bench for aim65_kbd_matrix. A driver applies one input set
// per clock and pushes the predicted outputs into a scoreboard queue; a
// monitor on the falling edge pops and compares. The prediction comes from
// a key-level model of the keyboard (pressed/pending/scan counts and PS/2
// prefix flags).
module tb_aim65_kbd_matrix;

  localparam int E1_SKIP      = 7;
  localparam int RELEASE_HOLD = 1;

  typedef struct {
    int         due;
    logic [7:0] row;
    logic       any;
    logic       busy;
    string      tag;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   last_due = 0;
  exp_t sb_q[$];

  aim65_kbd_matrix_if bus();

  aim65_kbd_matrix #(.E1_SKIP(E1_SKIP), .RELEASE_HOLD(RELEASE_HOLD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Keyboard model state.
  bit         m_key  [64];
  bit         m_pend [64];
  int         m_seen [64];
  bit         m_e0, m_f0;
  int         m_skip;
  logic [7:0] m_prev_col;

  logic [7:0] mapped_codes [27] = '{
    8'h5A, 8'h29, 8'h66, 8'h76, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h15,
    8'h1D, 8'h24, 8'h2D, 8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h1A, 8'h22,
    8'h21, 8'h2A, 8'h14, 8'h12, 8'h59, 8'h75, 8'h72, 8'h6B, 8'h74
  };

  // AIM-65 key position for a code, as col*8+row, or -1 when unmapped.
  function automatic int key_index(input bit ext, input logic [7:0] code);
    if (!ext) begin
      case (code)
        8'h5A: return 0*8 + 0;
        8'h29: return 0*8 + 1;
        8'h66: return 0*8 + 2;
        8'h76: return 0*8 + 3;
        8'h16: return 1*8 + 0;
        8'h1E: return 1*8 + 1;
        8'h26: return 1*8 + 2;
        8'h25: return 1*8 + 3;
        8'h15: return 2*8 + 0;
        8'h1D: return 2*8 + 1;
        8'h24: return 2*8 + 2;
        8'h2D: return 2*8 + 3;
        8'h1C: return 3*8 + 2;
        8'h1B: return 3*8 + 3;
        8'h23: return 3*8 + 4;
        8'h2B: return 3*8 + 5;
        8'h1A: return 4*8 + 0;
        8'h22: return 4*8 + 1;
        8'h21: return 4*8 + 2;
        8'h2A: return 4*8 + 3;
        8'h14: return 7*8 + 6;
        8'h12: return 7*8 + 7;
        8'h59: return 7*8 + 7;
        default: return -1;
      endcase
    end
    case (code)
      8'h75: return 1*8 + 5;
      8'h72: return 1*8 + 6;
      8'h6B: return 2*8 + 6;
      8'h74: return 2*8 + 7;
      default: return -1;
    endcase
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 64; k++) begin
      m_key[k]  = 1'b0;
      m_pend[k] = 1'b0;
      m_seen[k] = 0;
    end
    m_e0 = 1'b0;
    m_f0 = 1'b0;
    m_skip = 0;
    m_prev_col = 8'hFF;
  endfunction

  function automatic void model_make(input bit ext, input logic [7:0] code);
    int k;
    k = key_index(ext, code);
    if (k >= 0) begin
      if (!m_key[k]) begin
        m_key[k]  = 1'b1;
        m_seen[k] = 0;
      end
      m_pend[k] = 1'b0;
    end
  endfunction

  function automatic void model_break(input bit ext, input logic [7:0] code);
    int k;
    k = key_index(ext, code);
    if (k >= 0 && m_key[k]) begin
      if (m_seen[k] >= RELEASE_HOLD) begin
        m_key[k]  = 1'b0;
        m_pend[k] = 1'b0;
        m_seen[k] = 0;
      end else begin
        m_pend[k] = 1'b1;
      end
    end
  endfunction

  // One clock of the keyboard: outputs reflect the matrix before the edge,
  // then scans are counted, the byte applied and pending releases resolved.
  function automatic void model_step(input bit v, input logic [7:0] code,
                                     input logic [7:0] col, output logic [7:0] row,
                                     output logic any, output logic bsy);
    row = 8'hFF;
    any = 1'b0;
    for (int k = 0; k < 64; k++) begin
      if (m_key[k]) begin
        any = 1'b1;
        if (!col[k / 8]) row[k % 8] = 1'b0;
      end
    end
    for (int k = 0; k < 64; k++) begin
      if (m_key[k] && !col[k / 8] && (col != m_prev_col) && m_seen[k] < RELEASE_HOLD)
        m_seen[k]++;
    end
    if (v) begin
      if (m_skip > 0) begin
        m_skip--;
      end else if (m_f0) begin
        model_break(m_e0, code);
        m_e0 = 1'b0;
        m_f0 = 1'b0;
      end else if (code == 8'hF0) begin
        m_f0 = 1'b1;
      end else if (m_e0) begin
        model_make(1'b1, code);
        m_e0 = 1'b0;
      end else if (code == 8'hE0) begin
        m_e0 = 1'b1;
      end else if (code == 8'hE1) begin
        m_skip = E1_SKIP;
      end else if (code == 8'hAA || code == 8'hFF) begin
        for (int k = 0; k < 64; k++) begin
          m_key[k]  = 1'b0;
          m_pend[k] = 1'b0;
          m_seen[k] = 0;
        end
      end else begin
        model_make(1'b0, code);
      end
    end
    for (int k = 0; k < 64; k++) begin
      if (m_pend[k] && m_seen[k] >= RELEASE_HOLD) begin
        m_key[k]  = 1'b0;
        m_pend[k] = 1'b0;
        m_seen[k] = 0;
      end
    end
    m_prev_col = col;
    bsy = m_e0 || m_f0 || (m_skip > 0);
  endfunction

  task automatic push_exp(input logic [7:0] row, input logic any, input logic bsy,
                          input string tag);
    exp_t e;
    e.due  = cyc + 1;
    e.row  = row;
    e.any  = any;
    e.busy = bsy;
    e.tag  = tag;
    last_due = e.due;
    sb_q.push_back(e);
  endtask

  // Fixed expectation for the same edge as the latest applied stimulus.
  task automatic expectAt(input logic [7:0] row, input logic any, input logic bsy,
                          input string tag);
    exp_t e;
    e.due  = last_due;
    e.row  = row;
    e.any  = any;
    e.busy = bsy;
    e.tag  = tag;
    sb_q.push_back(e);
  endtask

  // Drives one clock's worth of inputs and predicts the result of that edge.
  task automatic applyStimulus(input bit v, input logic [7:0] code,
                               input logic [7:0] col, input string tag);
    logic [7:0] row_e;
    logic       any_e, busy_e;
    @(posedge clk);
    #2;
    bus.kbd_valid = v;
    bus.kbd_code  = code;
    bus.col_sel   = col;
    model_step(v, code, col, row_e, any_e, busy_e);
    push_exp(row_e, any_e, busy_e, tag);
  endtask

  task automatic doReset(input logic [7:0] col);
    logic [7:0] row_e;
    logic       any_e, busy_e;
    @(posedge clk);
    @(negedge clk);
    #1;
    reset = 1'b1;
    bus.kbd_valid = 1'b0;
    bus.kbd_code  = 8'h00;
    bus.col_sel   = col;
    model_reset();
    push_exp(8'hFF, 1'b0, 1'b0, "reset");
    @(posedge clk);
    #2;
    reset = 1'b0;
    model_step(1'b0, 8'h00, col, row_e, any_e, busy_e);
    push_exp(row_e, any_e, busy_e, "post_reset");
  endtask

  task automatic checkOutput(input exp_t e);
    checks++;
    if (bus.row_out !== e.row) begin
      failures++;
      $display("[TB] FAIL %s row_out: got %h expected %h (cycle %0d)", e.tag, bus.row_out, e.row, cyc);
    end
    checks++;
    if (bus.any_key !== e.any) begin
      failures++;
      $display("[TB] FAIL %s any_key: got %b expected %b (cycle %0d)", e.tag, bus.any_key, e.any, cyc);
    end
    checks++;
    if (bus.busy !== e.busy) begin
      failures++;
      $display("[TB] FAIL %s busy: got %b expected %b (cycle %0d)", e.tag, bus.busy, e.busy, cyc);
    end
  endtask

  // Monitor: compares every expectation when its edge has passed.
  initial begin
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
        if (sb_q[0].due < cyc) begin
          checks++;
          failures++;
          $display("[TB] FAIL %s stale: due cycle %0d checked at %0d", sb_q[0].tag, sb_q[0].due, cyc);
          void'(sb_q.pop_front());
        end else begin
          checkOutput(sb_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [7:0] col;
    logic [7:0] code;
    int         r;

    bus.kbd_valid = 1'b0;
    bus.kbd_code  = 8'h00;
    bus.col_sel   = 8'hF7;
    model_reset();

    // Reset, then a normal make of A at (col3,row2).
    doReset(8'hF7);
    applyStimulus(1'b1, 8'h1C, 8'hF7, "t1_make");
    expectAt(8'hFF, 1'b0, 1'b0, "t1_idle");
    applyStimulus(1'b0, 8'h00, 8'hF7, "t1_wait");
    expectAt(8'hFB, 1'b1, 1'b0, "t1_row");

    // Extended make and break of up-arrow at (col1,row5).
    applyStimulus(1'b1, 8'hE0, 8'hFD, "t2_e0");
    expectAt(8'hFF, 1'b1, 1'b1, "t2_busy");
    applyStimulus(1'b1, 8'h75, 8'hFD, "t2_make");
    applyStimulus(1'b0, 8'h00, 8'hFD, "t2_wait");
    expectAt(8'hDF, 1'b1, 1'b0, "t2_row");
    applyStimulus(1'b0, 8'h00, 8'hFF, "t2_unsel");
    applyStimulus(1'b0, 8'h00, 8'hFD, "t2_scan");
    applyStimulus(1'b1, 8'hE0, 8'hFD, "t2_brk_e0");
    applyStimulus(1'b1, 8'hF0, 8'hFD, "t2_brk_f0");
    applyStimulus(1'b1, 8'h75, 8'hFD, "t2_brk");
    applyStimulus(1'b0, 8'h00, 8'hFD, "t2_wait2");
    expectAt(8'hFF, 1'b1, 1'b0, "t2_released");

    // A tap between scans is held pending until one scan sees it.
    applyStimulus(1'b1, 8'h5A, 8'hFF, "t3_make");
    applyStimulus(1'b1, 8'hF0, 8'hFF, "t3_f0");
    applyStimulus(1'b1, 8'h5A, 8'hFF, "t3_brk");
    applyStimulus(1'b0, 8'h00, 8'hFF, "t3_hold");
    applyStimulus(1'b0, 8'h00, 8'hFE, "t3_scan");
    expectAt(8'hFE, 1'b1, 1'b0, "t3_seen");
    applyStimulus(1'b0, 8'h00, 8'hFF, "t3_unsel");
    applyStimulus(1'b0, 8'h00, 8'hFE, "t3_rescan");
    expectAt(8'hFF, 1'b1, 1'b0, "t3_gone");

    // Two columns low give the OR of their rows; AA clears everything.
    applyStimulus(1'b1, 8'h12, 8'h77, "t4_shift");
    applyStimulus(1'b1, 8'h1C, 8'h77, "t4_repeat");
    applyStimulus(1'b0, 8'h00, 8'h77, "t4_wait");
    expectAt(8'h7B, 1'b1, 1'b0, "t4_or");
    applyStimulus(1'b1, 8'hAA, 8'h77, "t4_bat");
    applyStimulus(1'b0, 8'h00, 8'h77, "t4_wait2");
    expectAt(8'hFF, 1'b0, 1'b0, "t4_cleared");

    // E1 swallows the following bytes, even mapped ones.
    applyStimulus(1'b1, 8'hE1, 8'hF7, "t5_e1");
    for (int i = 0; i < E1_SKIP; i++) begin
      applyStimulus(1'b1, (i == 3) ? 8'h1C : 8'h14 + 8'(i), 8'hF7, "t5_skip");
      if (i < E1_SKIP - 1) expectAt(8'hFF, 1'b0, 1'b1, "t5_busy");
    end
    expectAt(8'hFF, 1'b0, 1'b0, "t5_done");
    applyStimulus(1'b1, 8'h1C, 8'hF7, "t5_make");
    applyStimulus(1'b0, 8'h00, 8'hF7, "t5_wait");
    expectAt(8'hFB, 1'b1, 1'b0, "t5_row");

    // Reset between E0 and F0 aborts the sequence.
    applyStimulus(1'b1, 8'hE0, 8'hFF, "t6_e0");
    doReset(8'h00);
    applyStimulus(1'b1, 8'hF0, 8'h00, "t6_f0");
    applyStimulus(1'b1, 8'h75, 8'h00, "t6_brk75");
    applyStimulus(1'b1, 8'h75, 8'h00, "t6_make75");
    applyStimulus(1'b0, 8'h00, 8'h00, "t6_wait");
    expectAt(8'hFF, 1'b0, 1'b0, "t6_unmapped");

    // Randomized traffic against the model.
    col = 8'hFF;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) < 30) begin
        r = $urandom_range(0, 99);
        if (r < 40)      col = ~(8'h01 << $urandom_range(0, 7));
        else if (r < 60) col = 8'hFF;
        else             col = 8'($urandom);
      end
      if ($urandom_range(0, 399) == 0) begin
        doReset(col);
      end else if ($urandom_range(0, 99) < 40) begin
        r = $urandom_range(0, 99);
        if (r < 15)      code = 8'hE0;
        else if (r < 35) code = 8'hF0;
        else if (r < 37) code = 8'hE1;
        else if (r < 38) code = 8'hAA;
        else if (r < 43) code = 8'($urandom);
        else             code = mapped_codes[$urandom_range(0, 26)];
        applyStimulus(1'b1, code, col, "rand_byte");
      end else begin
        applyStimulus(1'b0, 8'h00, col, "rand_idle");
      end
    end

    applyStimulus(1'b0, 8'h00, 8'hFF, "final");
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
